// File: rtl/cam_rx_word_aligner_pkg.sv
// Shared constants and lane state encoding for the camera LVDS word aligner.
// Imported by the lane FSM and the per-camera top.
package cam_rx_word_aligner_pkg;

  localparam int LANE_W = 8;
  localparam int SLIP_W = 5;

  localparam logic [LANE_W-1:0] DEF_TRAIN = 8'h3A;
  localparam int DEF_MATCH_COUNT = 16;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_MAX_SLIPS = 16;

  typedef enum logic [2:0] {
    L_IDLE,
    L_CHECK,
    L_SLIP,
    L_SETTLE,
    L_LOCKED,
    L_FAIL
  } lane_st_e;

endpackage

// File: rtl/cam_rx_lane_aligner.sv
// One lane of bitslip training: match counter, slip pulse, settle wait.
// Outputs are registered straight from the FSM.
import cam_rx_word_aligner_pkg::*;

module cam_rx_lane_aligner #(
  parameter logic [LANE_W-1:0] TRAIN = DEF_TRAIN,
  parameter int MATCH_COUNT = DEF_MATCH_COUNT,
  parameter int SETTLE = DEF_SETTLE,
  parameter int MAX_SLIPS = DEF_MAX_SLIPS
) (
  input  logic              c,
  input  logic              rst,
  input  logic              rx_locked,
  input  logic              start,
  input  logic [LANE_W-1:0] word,
  output logic              slip,
  output logic              locked,
  output logic              failed,
  output logic [SLIP_W-1:0] slip_cnt
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [SLIP_W-1:0] SLIP_LIMIT = SLIP_W'(MAX_SLIPS);

  lane_st_e state;
  logic [MW-1:0] match_cnt;
  logic [TW-1:0] settle_cnt;

  always_ff @(posedge c) begin
    if (rst || !rx_locked || start) begin
      state      <= (rst || !rx_locked) ? L_IDLE : L_CHECK;
      match_cnt  <= '0;
      settle_cnt <= '0;
      slip_cnt   <= '0;
      slip       <= 1'b0;
      locked     <= 1'b0;
      failed     <= 1'b0;
    end else begin
      slip <= 1'b0;
      unique case (state)
        L_CHECK: begin
          if (word == TRAIN) begin
            if (match_cnt == MATCH_LAST) begin
              state  <= L_LOCKED;
              locked <= 1'b1;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            match_cnt <= '0;
            if (slip_cnt == SLIP_LIMIT) begin
              state  <= L_FAIL;
              failed <= 1'b1;
            end else begin
              state <= L_SLIP;
              slip  <= 1'b1;
            end
          end
        end
        L_SLIP: begin
          if (slip_cnt != '1)
            slip_cnt <= slip_cnt + 1'b1;
          settle_cnt <= '0;
          state      <= L_SETTLE;
        end
        // deserializer output still reflects the old bit offset here
        L_SETTLE: begin
          if (settle_cnt == SETTLE_LAST)
            state <= L_CHECK;
          else
            settle_cnt <= settle_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cam_rx_word_aligner.sv
// Per-camera word aligner: one training FSM per deserializer lane,
// plus registered all-locked / any-failed summary flags.
import cam_rx_word_aligner_pkg::*;

module cam_rx_word_aligner #(
  parameter int LANES = 5,
  parameter logic [LANE_W-1:0] TRAIN = DEF_TRAIN,
  parameter int MATCH_COUNT = DEF_MATCH_COUNT,
  parameter int SETTLE = DEF_SETTLE,
  parameter int MAX_SLIPS = DEF_MAX_SLIPS
) (
  input  logic                     c,
  input  logic                     rst,
  input  logic                     rx_locked,
  input  logic                     start,
  input  logic [LANE_W*LANES-1:0]  rxd,
  output logic [LANES-1:0]         rxd_align,
  output logic [LANES-1:0]         lane_aligned,
  output logic                     aligned,
  output logic                     fail,
  output logic [SLIP_W*LANES-1:0]  slip_count
);

  logic [LANES-1:0] lane_fail;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    cam_rx_lane_aligner #(
      .TRAIN       (TRAIN),
      .MATCH_COUNT (MATCH_COUNT),
      .SETTLE      (SETTLE),
      .MAX_SLIPS   (MAX_SLIPS)
    ) u_lane (
      .c         (c),
      .rst       (rst),
      .rx_locked (rx_locked),
      .start     (start),
      .word      (rxd[LANE_W*n +: LANE_W]),
      .slip      (rxd_align[n]),
      .locked    (lane_aligned[n]),
      .failed    (lane_fail[n]),
      .slip_cnt  (slip_count[SLIP_W*n +: SLIP_W])
    );
  end

  always_ff @(posedge c) begin
    if (rst) begin
      aligned <= 1'b0;
      fail    <= 1'b0;
    end else begin
      aligned <= &lane_aligned;
      fail    <= |lane_fail;
    end
  end

endmodule
